// File: rtl/game_pkg.sv
// Shared game types and per-character default tuning.
// Motion states are exported as a 3-bit enum for the sprite animator.
package game_pkg;

    typedef enum logic [2:0] {
        MS_SPAWN   = 3'd0,
        MS_IDLE    = 3'd1,
        MS_MOVING  = 3'd2,
        MS_JUMPING = 3'd3,
        MS_FALLING = 3'd4
    } motion_state_t;

    localparam int TOM_SPAWN_X     = 500;
    localparam int TOM_SPAWN_Y     = 703;
    localparam int TOM_JUMP_H      = 200;
    localparam int JERRY_SPAWN_X   = 200;
    localparam int JERRY_SPAWN_Y   = 703;
    localparam int JERRY_JUMP_H    = 260;

    localparam int DEF_X_TICK       = 400000;
    localparam int DEF_Y_TICK_START = 400000;
    localparam int DEF_Y_TICK_MAX   = 800000;
    localparam int DEF_Y_TICK_MIN   = 200000;
    localparam int DEF_Y_STEP_UP    = 10000;
    localparam int DEF_Y_STEP_DN    = 20000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/char_motion_ctrl_if.sv
// Control/collision inputs and position outputs of one character.
// master drives requests and checker flags, slave is the controller.
interface char_motion_ctrl_if #(
    parameter int X_W = 11,
    parameter int Y_W = 10
) ();

    logic                      left;
    logic                      right;
    logic                      jump;
    logic                      freeze;
    logic                      respawn;
    logic                      floor_hit;
    logic                      ceil_hit;
    logic [X_W-1:0]            x;
    logic [Y_W-1:0]            y;
    logic                      facing_left;
    game_pkg::motion_state_t   mstate;

    modport master (
        output left, right, jump, freeze, respawn,
        output floor_hit, ceil_hit,
        input  x, y, facing_left, mstate
    );

    modport slave (
        input  left, right, jump, freeze, respawn,
        input  floor_hit, ceil_hit,
        output x, y, facing_left, mstate
    );

endinterface

// File: rtl/char_motion_ctrl_axis_stepper.sv
// One motion axis: tick counter plus saturating +/-1 position step.
// The counter still restarts when a step is blocked by a bound.
module axis_stepper #(
    parameter int POS_W   = 11,
    parameter int CNT_W   = 19,
    parameter int MIN_POS = 0,
    parameter int MAX_POS = 960
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             load,
    input  logic [POS_W-1:0] load_pos,
    input  logic             clr,
    input  logic             en,
    input  logic             inc,
    input  logic [CNT_W-1:0] period,
    output logic [POS_W-1:0] pos,
    output logic             step
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_inc;
    logic             at_tick;
    logic             advance;

    assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
    assign at_tick = cnt_inc >= {1'b0, period};
    assign advance = en && !hold && !load && !clr;
    assign step    = advance && at_tick;

    // counter and position update, saturating at the axis bounds
    always_ff @(posedge clk) begin
        if (rst) begin
            pos <= '0;
            cnt <= '0;
        end else if (!hold) begin
            if (load) begin
                pos <= load_pos;
                cnt <= '0;
            end else if (clr || !en) begin
                cnt <= '0;
            end else if (at_tick) begin
                cnt <= '0;
                if (inc && pos < POS_W'(MAX_POS))
                    pos <= pos + POS_W'(1);
                else if (!inc && pos > POS_W'(MIN_POS))
                    pos <= pos - POS_W'(1);
            end else begin
                cnt <= cnt_inc[CNT_W-1:0];
            end
        end
    end

endmodule

// File: rtl/char_motion_ctrl.sv
// Per-character walk/jump/fall controller with spawn, freeze and clamps.
// Optional macro DOUBLE_JUMP_EN allows one extra jump per airtime.
module char_motion_ctrl
    import game_pkg::*;
#(
    parameter int X_W          = 11,
    parameter int Y_W          = 10,
    parameter int SCR_W        = 1024,
    parameter int SCR_H        = 768,
    parameter int CHAR_W       = 64,
    parameter int CHAR_H       = 64,
    parameter int SPAWN_X      = 500,
    parameter int SPAWN_Y      = 703,
    parameter int X_TICK       = 400000,
    parameter int Y_TICK_START = 400000,
    parameter int Y_TICK_MAX   = 800000,
    parameter int Y_TICK_MIN   = 200000,
    parameter int Y_STEP_UP    = 10000,
    parameter int Y_STEP_DN    = 20000,
    parameter int JUMP_H       = 200
) (
    input logic               clk,
    input logic               rst,
    char_motion_ctrl_if.slave bus
);

    localparam int XC_W   = $clog2(X_TICK + 1);
    localparam int YT_TOP = max2(Y_TICK_MAX, Y_TICK_START);
    localparam int YC_W   = $clog2(YT_TOP + 1);
    localparam int X_HI   = SCR_W - CHAR_W;
    localparam int Y_HI   = SCR_H - CHAR_H;

    motion_state_t  state;
    motion_state_t  next;
    logic [X_W-1:0] x_pos;
    logic [Y_W-1:0] y_pos;
    logic [Y_W-1:0] jump_start;
    logic [Y_W-1:0] jump_floor;
    logic [YC_W-1:0] y_period;
    logic [YC_W-1:0] yp_rise;
    logic [YC_W-1:0] yp_fall;
    logic [YC_W:0]   yp_wide_up;
    logic facing;
    logic hold;
    logic spawn_load;
    logic grounded;
    logic one_dir;
    logic top_reached;
    logic x_en;
    logic x_step;
    logic y_en;
    logic y_inc;
    logic y_clr;
    logic y_step;
    logic start_jump;
    logic land;
    logic air_take;

    // respawn overrides freeze so a frozen character can still be reset
    assign hold       = bus.freeze && !bus.respawn;
    assign spawn_load = (state == MS_SPAWN) && !bus.respawn;
    assign grounded   = bus.floor_hit || (y_pos == Y_W'(Y_HI));
    assign one_dir    = bus.left ^ bus.right;

    assign jump_floor = (jump_start >= Y_W'(JUMP_H)) ?
                        jump_start - Y_W'(JUMP_H) : '0;
    assign top_reached = (y_pos <= jump_floor) || bus.ceil_hit ||
                         (y_pos == '0);

    assign x_en = one_dir && ((state == MS_MOVING) ||
                              (state == MS_JUMPING) ||
                              (state == MS_FALLING));

    assign y_clr = start_jump || (next != state);

    assign yp_wide_up = {1'b0, y_period} + (YC_W+1)'(Y_STEP_UP);
    assign yp_rise = (yp_wide_up > (YC_W+1)'(Y_TICK_MAX)) ?
                     YC_W'(Y_TICK_MAX) : yp_wide_up[YC_W-1:0];
    assign yp_fall = ({1'b0, y_period} >=
                      (YC_W+1)'(Y_TICK_MIN + Y_STEP_DN)) ?
                     y_period - YC_W'(Y_STEP_DN) : YC_W'(Y_TICK_MIN);

`ifdef DOUBLE_JUMP_EN
    logic jump_q;
    logic air_used;

    assign air_take = bus.jump && !jump_q && !air_used &&
                      ((state == MS_JUMPING) ||
                       (state == MS_FALLING && !grounded));

    // jump edge history and the one-per-airtime flag
    always_ff @(posedge clk) begin
        if (rst) begin
            jump_q   <= 1'b0;
            air_used <= 1'b0;
        end else if (bus.respawn) begin
            jump_q   <= bus.jump;
            air_used <= 1'b0;
        end else if (!bus.freeze) begin
            jump_q <= bus.jump;
            if (land)
                air_used <= 1'b0;
            else if (air_take)
                air_used <= 1'b1;
        end
    end
`else
    assign air_take = 1'b0;
`endif

    axis_stepper #(
        .POS_W  (X_W),
        .CNT_W  (XC_W),
        .MIN_POS(0),
        .MAX_POS(X_HI)
    ) u_x (
        .clk     (clk),
        .rst     (rst),
        .hold    (hold),
        .load    (spawn_load),
        .load_pos(X_W'(SPAWN_X)),
        .clr     (bus.respawn),
        .en      (x_en),
        .inc     (bus.right),
        .period  (XC_W'(X_TICK)),
        .pos     (x_pos),
        .step    (x_step)
    );

    axis_stepper #(
        .POS_W  (Y_W),
        .CNT_W  (YC_W),
        .MIN_POS(0),
        .MAX_POS(Y_HI)
    ) u_y (
        .clk     (clk),
        .rst     (rst),
        .hold    (hold),
        .load    (spawn_load),
        .load_pos(Y_W'(SPAWN_Y)),
        .clr     (y_clr || bus.respawn),
        .en      (y_en),
        .inc     (y_inc),
        .period  (y_period),
        .pos     (y_pos),
        .step    (y_step)
    );

    // next-state decode; vertical motion only while staying in the air
    always_comb begin
        next       = state;
        start_jump = 1'b0;
        land       = 1'b0;
        y_en       = 1'b0;
        y_inc      = 1'b0;
        unique case (state)
            MS_SPAWN: next = MS_IDLE;
            MS_IDLE: begin
                if (bus.jump && grounded) begin
                    next       = MS_JUMPING;
                    start_jump = 1'b1;
                end else if (one_dir) begin
                    next = MS_MOVING;
                end else if (!grounded) begin
                    next = MS_FALLING;
                end
            end
            MS_MOVING: begin
                if (bus.jump && grounded) begin
                    next       = MS_JUMPING;
                    start_jump = 1'b1;
                end else if (!grounded) begin
                    next = MS_FALLING;
                end else if (!one_dir) begin
                    next = MS_IDLE;
                end
            end
            MS_JUMPING: begin
                if (air_take)
                    start_jump = 1'b1;
                else if (top_reached)
                    next = MS_FALLING;
                else
                    y_en = 1'b1;
            end
            MS_FALLING: begin
                if (grounded) begin
                    land = 1'b1;
                    next = one_dir ? MS_MOVING : MS_IDLE;
                end else if (air_take) begin
                    next       = MS_JUMPING;
                    start_jump = 1'b1;
                end else begin
                    y_en  = 1'b1;
                    y_inc = 1'b1;
                end
            end
            default: next = MS_SPAWN;
        endcase
    end

    // state, facing, jump origin and vertical period registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= MS_SPAWN;
            y_period   <= '0;
            jump_start <= '0;
            facing     <= 1'b0;
        end else if (bus.respawn) begin
            state    <= MS_SPAWN;
            y_period <= '0;
        end else if (!bus.freeze) begin
            state <= next;
            if (x_step)
                facing <= bus.left;
            if (start_jump)
                jump_start <= y_pos;
            if (state == MS_SPAWN || start_jump || land)
                y_period <= YC_W'(Y_TICK_START);
            else if (y_step)
                y_period <= (state == MS_JUMPING) ? yp_rise : yp_fall;
        end
    end

    assign bus.x           = x_pos;
    assign bus.y           = y_pos;
    assign bus.facing_left = facing;
    assign bus.mstate      = state;

endmodule

// File: tb/tb_char_motion_ctrl.sv
// Directed bench for char_motion_ctrl with shortened tick periods.
// Floor/ceiling checker is modelled as simple y-coordinate matches.
module tb_char_motion_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    logic       floor_on = 1'b1;
    logic [9:0] floor_y  = 10'd703;
    logic       ceil_on  = 1'b0;
    logic [9:0] ceil_y   = 10'd700;

    localparam int ST_SPAWN = 0;
    localparam int ST_IDLE  = 1;
    localparam int ST_MOVE  = 2;
    localparam int ST_JUMP  = 3;
    localparam int ST_FALL  = 4;

    char_motion_ctrl_if #(.X_W(11), .Y_W(10)) bus ();

    assign bus.floor_hit = floor_on && (bus.y == floor_y);
    assign bus.ceil_hit  = ceil_on && (bus.y == ceil_y);

    char_motion_ctrl #(
        .X_TICK      (4),
        .Y_TICK_START(8),
        .Y_TICK_MAX  (12),
        .Y_TICK_MIN  (4),
        .Y_STEP_UP   (2),
        .Y_STEP_DN   (2),
        .JUMP_H      (5),
        .SPAWN_X     (500),
        .SPAWN_Y     (703)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            cyc(1);
            if (int'(bus.mstate) == ST_IDLE) break;
        end
        chk("land_idle", int'(bus.mstate), ST_IDLE);
    endtask

    initial begin
        bus.left = 0;
        bus.right = 0;
        bus.jump = 0;
        bus.freeze = 0;
        bus.respawn = 0;

        cyc(3);
        chk("rst_state", int'(bus.mstate), ST_SPAWN);
        chk("rst_x", int'(bus.x), 0);
        chk("rst_y", int'(bus.y), 0);
        chk("rst_face", int'(bus.facing_left), 0);
        rst = 0;
        cyc(1);
        chk("spawn_state", int'(bus.mstate), ST_IDLE);
        chk("spawn_x", int'(bus.x), 500);
        chk("spawn_y", int'(bus.y), 703);
        cyc(3);
        chk("idle_hold", int'(bus.mstate), ST_IDLE);

        bus.right = 1;
        cyc(16);
        chk("walk_r_16", int'(bus.x), 503);
        cyc(1);
        chk("walk_r_17", int'(bus.x), 504);
        chk("walk_r_state", int'(bus.mstate), ST_MOVE);
        chk("walk_r_face", int'(bus.facing_left), 0);
        cyc(2);
        bus.left = 1;
        cyc(1);
        chk("both_idle", int'(bus.mstate), ST_IDLE);
        cyc(3);
        chk("both_hold_x", int'(bus.x), 504);
        bus.left = 0;
        cyc(4);
        chk("cnt_reset_4", int'(bus.x), 504);
        cyc(1);
        chk("cnt_reset_5", int'(bus.x), 505);
        bus.right = 0;
        cyc(1);
        chk("stop_idle", int'(bus.mstate), ST_IDLE);

        bus.freeze = 1;
        bus.right = 1;
        cyc(10);
        chk("freeze_x", int'(bus.x), 505);
        chk("freeze_state", int'(bus.mstate), ST_IDLE);
        bus.freeze = 0;
        bus.right = 0;
        bus.left = 1;
        cyc(5);
        chk("walk_l_x", int'(bus.x), 504);
        chk("walk_l_face", int'(bus.facing_left), 1);
        bus.left = 0;
        cyc(1);
        chk("walk_l_stop", int'(bus.mstate), ST_IDLE);

        bus.jump = 1;
        cyc(1);
        bus.jump = 0;
        chk("jump_enter", int'(bus.mstate), ST_JUMP);
        cyc(7);
        chk("rise_p8_pre", int'(bus.y), 703);
        cyc(1);
        chk("rise_p8", int'(bus.y), 702);
        cyc(10);
        chk("rise_p10", int'(bus.y), 701);
        cyc(12);
        chk("rise_p12a", int'(bus.y), 700);
        cyc(12);
        chk("rise_p12b", int'(bus.y), 699);
        cyc(12);
        chk("rise_p12c", int'(bus.y), 698);
        chk("apex_state", int'(bus.mstate), ST_JUMP);
        cyc(1);
        chk("fall_enter", int'(bus.mstate), ST_FALL);
        cyc(11);
        chk("fall_p12_pre", int'(bus.y), 698);
        cyc(1);
        chk("fall_p12", int'(bus.y), 699);
        cyc(10);
        chk("fall_p10", int'(bus.y), 700);
        cyc(8);
        chk("fall_p8", int'(bus.y), 701);
        cyc(6);
        chk("fall_p6", int'(bus.y), 702);
        cyc(4);
        chk("fall_p4", int'(bus.y), 703);
        chk("fall_p4_state", int'(bus.mstate), ST_FALL);
        cyc(1);
        chk("land_state", int'(bus.mstate), ST_IDLE);

        ceil_on = 1;
        bus.jump = 1;
        cyc(1);
        bus.jump = 0;
        cyc(30);
        chk("ceil_y", int'(bus.y), 700);
        chk("ceil_pre_state", int'(bus.mstate), ST_JUMP);
        cyc(1);
        chk("ceil_fall", int'(bus.mstate), ST_FALL);
        cyc(11);
        chk("ceil_no_rise", int'(bus.y), 700);
        cyc(1);
        chk("ceil_fall_701", int'(bus.y), 701);
        cyc(18);
        chk("ceil_fall_703", int'(bus.y), 703);
        cyc(1);
        chk("ceil_land", int'(bus.mstate), ST_IDLE);
        ceil_on = 0;

`ifdef DOUBLE_JUMP_EN
        bus.jump = 1;
        cyc(1);
        bus.jump = 0;
        cyc(54);
        chk("dj_apex1", int'(bus.y), 698);
        cyc(1);
        chk("dj_fall1", int'(bus.mstate), ST_FALL);
        cyc(12);
        chk("dj_fall1_y", int'(bus.y), 699);
        cyc(3);
        bus.jump = 1;
        cyc(1);
        bus.jump = 0;
        chk("dj_air_jump", int'(bus.mstate), ST_JUMP);
        cyc(8);
        chk("dj_rise1", int'(bus.y), 698);
        cyc(46);
        chk("dj_apex2", int'(bus.y), 694);
        cyc(1);
        chk("dj_fall2", int'(bus.mstate), ST_FALL);
        cyc(3);
        bus.jump = 1;
        cyc(1);
        bus.jump = 0;
        chk("dj_third_ign", int'(bus.mstate), ST_FALL);
        cyc(8);
        chk("dj_third_y", int'(bus.y), 695);
        wait_idle(400);
        chk("dj_land_y", int'(bus.y), 703);

        bus.jump = 1;
        cyc(1);
        bus.jump = 0;
        cyc(1);
        bus.jump = 1;
        cyc(1);
        bus.jump = 0;
        cyc(6);
        chk("dj_flag_clr8", int'(bus.y), 703);
        cyc(2);
        chk("dj_flag_clr10", int'(bus.y), 702);
        wait_idle(400);
`else
        bus.jump = 1;
        cyc(1);
        bus.jump = 0;
        cyc(1);
        bus.jump = 1;
        cyc(1);
        bus.jump = 0;
        cyc(6);
        chk("air_jump_ign", int'(bus.y), 702);
        wait_idle(400);
`endif

        bus.respawn = 1;
        bus.freeze = 1;
        cyc(1);
        bus.respawn = 0;
        bus.freeze = 0;
        chk("respawn_state", int'(bus.mstate), ST_SPAWN);
        chk("respawn_xhold", int'(bus.x), 504);
        cyc(1);
        chk("respawn_idle", int'(bus.mstate), ST_IDLE);
        chk("respawn_x", int'(bus.x), 500);
        chk("respawn_y", int'(bus.y), 703);

        bus.right = 1;
        cyc(1801);
        chk("ledge_x", int'(bus.x), 950);
        chk("ledge_move", int'(bus.mstate), ST_MOVE);
        floor_on = 0;
        cyc(1);
        chk("walk_off", int'(bus.mstate), ST_FALL);
        cyc(8);
        chk("walk_off_y", int'(bus.y), 704);
        cyc(1);
        chk("walk_off_land", int'(bus.mstate), ST_MOVE);
        cyc(30);
        chk("clamp_x", int'(bus.x), 960);
        cyc(20);
        chk("clamp_hold", int'(bus.x), 960);
        chk("clamp_face", int'(bus.facing_left), 0);
        bus.right = 0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
